// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: I2S clock master and transmitter for stereo sample pairs.
// Sample pairs arrive on a valid/ready stream into a one-pair holding buffer. At each
// frame start the buffered pair moves into the transmit registers and is shifted out
// MSB first, one BCLK after each LRCLK edge.
// Optional build macro I2S_TX_REPEAT_ON_UNDERRUN_EN: an underrun frame resends the last
// loaded pair instead of silence.
module i2s_tx_serializer #(
    parameter int unsigned SAMPLE_WIDTH = 24,
    parameter int unsigned SLOT_WIDTH   = 32,
    parameter int unsigned BCLK_DIV     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [SAMPLE_WIDTH-1:0] s_left,
    input  logic [SAMPLE_WIDTH-1:0] s_right,
    output logic                    i2s_bclk,
    output logic                    i2s_lrclk,
    output logic                    i2s_sdata,
    output logic                    underrun,
    output logic [15:0]             underrun_count
);

    localparam int unsigned DivW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned CntW = $clog2(2 * SLOT_WIDTH);

    localparam logic [DivW-1:0] DivLast = DivW'(BCLK_DIV - 1);
    localparam logic [CntW-1:0] BitLast = CntW'(2 * SLOT_WIDTH - 1);
    localparam logic [CntW-1:0] SlotLen = CntW'(SLOT_WIDTH);

    // Clock generation and frame position
    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic            bclk_q, bclk_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic            lrclk_q, lrclk_d;
    logic            sdata_q, sdata_d;

    // Input stream and holding buffer
    logic                    ready_q, ready_d;
    logic                    buf_full_q, buf_full_d;
    logic [SAMPLE_WIDTH-1:0] buf_l_q, buf_l_d;
    logic [SAMPLE_WIDTH-1:0] buf_r_q, buf_r_d;

    // Pair currently on the wire
    logic [SAMPLE_WIDTH-1:0] tx_l_q, tx_l_d;
    logic [SAMPLE_WIDTH-1:0] tx_r_q, tx_r_d;

    // Underrun status
    logic        underrun_q, underrun_d;
    logic [15:0] urun_cnt_q, urun_cnt_d;

    // Events and helpers
    logic                    bclk_toggle;
    logic                    fall_event;
    logic                    frame_start;
    logic                    xfer;
    logic [CntW-1:0]         bit_cnt_nxt;
    logic [CntW-1:0]         slot_pos;
    logic                    lrclk_nxt;
    logic                    sdata_nxt;
    logic [SAMPLE_WIDTH-1:0] active;

    // BCLK divider: toggles bclk every BCLK_DIV clk cycles
    always_comb begin
        bclk_toggle = (div_cnt_q == DivLast);
        div_cnt_d   = bclk_toggle ? '0 : div_cnt_q + DivW'(1);
        bclk_d      = bclk_toggle ? ~bclk_q : bclk_q;
        fall_event  = bclk_toggle & bclk_q;
        frame_start = fall_event & (bit_cnt_q == BitLast);
    end

    // Bit position, word select and serial data, all advanced on the falling event
    always_comb begin
        bit_cnt_nxt = (bit_cnt_q == BitLast) ? '0 : bit_cnt_q + CntW'(1);
        lrclk_nxt   = (bit_cnt_nxt >= SlotLen);
        slot_pos    = lrclk_nxt ? (bit_cnt_nxt - SlotLen) : bit_cnt_nxt;
        active      = lrclk_nxt ? tx_r_q : tx_l_q;
        // Slot position p carries sample bit SAMPLE_WIDTH-p; p=0 is the one-BCLK delay
        sdata_nxt   = 1'b0;
        for (int unsigned i = 0; i < SAMPLE_WIDTH; i++) begin
            if (slot_pos == CntW'(SAMPLE_WIDTH - i)) begin
                sdata_nxt = active[i];
            end
        end
        bit_cnt_d = fall_event ? bit_cnt_nxt : bit_cnt_q;
        lrclk_d   = fall_event ? lrclk_nxt : lrclk_q;
        sdata_d   = fall_event ? sdata_nxt : sdata_q;
    end

    // Holding buffer fill/drain and transmit register load at frame start
    always_comb begin
        xfer       = s_valid & ready_q;
        buf_full_d = buf_full_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        tx_l_d     = tx_l_q;
        tx_r_d     = tx_r_q;
        if (frame_start) begin
            if (buf_full_q) begin
                tx_l_d     = buf_l_q;
                tx_r_d     = buf_r_q;
                buf_full_d = 1'b0;
            end else begin
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
                // Keep the previous pair; registers are zero until the first load
                tx_l_d = tx_l_q;
                tx_r_d = tx_r_q;
`else
                tx_l_d = '0;
                tx_r_d = '0;
`endif
            end
        end
        // A pair accepted on a frame-start cycle is held for the following frame
        if (xfer) begin
            buf_l_d    = s_left;
            buf_r_d    = s_right;
            buf_full_d = 1'b1;
        end
        ready_d = ~buf_full_d;
    end

    // Underrun pulse and saturating counter
    always_comb begin
        underrun_d = frame_start & ~buf_full_q;
        urun_cnt_d = urun_cnt_q;
        if (underrun_d && (urun_cnt_q != 16'hFFFF)) begin
            urun_cnt_d = urun_cnt_q + 16'd1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            bclk_q     <= 1'b0;
            bit_cnt_q  <= BitLast;
            lrclk_q    <= 1'b1;
            sdata_q    <= 1'b0;
            ready_q    <= 1'b0;
            buf_full_q <= 1'b0;
            buf_l_q    <= '0;
            buf_r_q    <= '0;
            tx_l_q     <= '0;
            tx_r_q     <= '0;
            underrun_q <= 1'b0;
            urun_cnt_q <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bclk_q     <= bclk_d;
            bit_cnt_q  <= bit_cnt_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            ready_q    <= ready_d;
            buf_full_q <= buf_full_d;
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            tx_l_q     <= tx_l_d;
            tx_r_q     <= tx_r_d;
            underrun_q <= underrun_d;
            urun_cnt_q <= urun_cnt_d;
        end
    end

    assign s_ready        = ready_q;
    assign i2s_bclk       = bclk_q;
    assign i2s_lrclk      = lrclk_q;
    assign i2s_sdata      = sdata_q;
    assign underrun       = underrun_q;
    assign underrun_count = urun_cnt_q;

endmodule
